axi4_if_encoding: RTL and testbench
===================================

Name: axi4_if_encoding

Overview:
- Write-direction AXI4 master encoder, the counterpart to the AW/W slave-side decoder.
- Accepts one decoded write command per handshake: address, beat count and a packed write-data chunk of up to CHUNK_MAX_BEATS beats.
- Drives it out as an AXI4 INCR burst on the AW and W master channels.
- Consumes B responses, tracks outstanding bursts, and flags error responses to the upstream request logic.

Parameters:
ID_WIDTH, 4, width of AWID/BID
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 256, W beat width in bits
CHUNK_MAX_BEATS, 4, max beats per command; in_wdata width = CHUNK_MAX_BEATS*DATA_WIDTH
MAX_OUTSTANDING, 4, max AW-issued bursts awaiting B

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
in_addr  input  ADDR_WIDTH  burst start byte address, DATA_WIDTH/8-aligned
in_length  input  8  beat count 1..CHUNK_MAX_BEATS (0 treated as 1)
in_wdata  input  CHUNK_MAX_BEATS*DATA_WIDTH  beat k in bits [k*DATA_WIDTH +: DATA_WIDTH]
in_valid  input  1  command valid
in_ready  output  1  command accepted when in_valid&in_ready
m_axi_awid  output  ID_WIDTH  burst ID
m_axi_awaddr  output  ADDR_WIDTH  burst address
m_axi_awlen  output  8  beats-1
m_axi_awsize  output  3  constant log2(DATA_WIDTH/8)
m_axi_awburst  output  2  constant 2'b01 (INCR)
m_axi_awvalid  output  1  AW valid
m_axi_awready  input  1  AW ready
m_axi_wdata  output  DATA_WIDTH  beat data
m_axi_wstrb  output  DATA_WIDTH/8  all ones
m_axi_wlast  output  1  last beat of burst
m_axi_wvalid  output  1  W valid
m_axi_wready  input  1  W ready
m_axi_bid  input  ID_WIDTH  response ID
m_axi_bresp  input  2  response code
m_axi_bvalid  input  1  B valid
m_axi_bready  output  1  B ready
err_valid  output  1  one-cycle pulse on a B handshake with bresp!=0
err_id  output  ID_WIDTH  BID of the error response, held until next error
outstanding  output  $clog2(MAX_OUTSTANDING+1)  bursts awaiting B

Behaviour:
- Reset (async, rst=1): FSM=IDLE. All valids low. err_valid=0, err_id=0, outstanding=0, ID counter=0. Command register cleared. m_axi_bready=0 during reset, 1 otherwise. A burst in flight at reset is abandoned; no partial W continuation after release.
- States:
  - IDLE: in_ready=1 iff outstanding<MAX_OUTSTANDING. On accept, latch addr/beats/wdata and go to SEND. awvalid and wvalid both assert in the next cycle (1-cycle latency).
  - SEND: AW and W progress independently.
    - AW: awvalid drops after its handshake (aw_done flag).
    - W: beat counter 0..beats-1; wdata=latched beat[counter]; wlast=(counter==beats-1); counter advances on wvalid&wready.
    - Exit to IDLE when aw_done and the wlast handshake has occurred; same-cycle completion of both is allowed. in_ready=0 throughout SEND.
- AW/W stability: awid/awaddr/awlen and wdata/wlast stay stable while the matching valid is high and ready is low.
- IDs: awid = ID counter, incremented (mod 2^ID_WIDTH) on each AW handshake.
- outstanding: +1 on AW handshake, -1 on B handshake, unchanged when both occur in the same cycle. A B handshake when outstanding==0 is ignored (no underflow).
- in_length outside 1..CHUNK_MAX_BEATS: 0 maps to 1; values >CHUNK_MAX_BEATS saturate to CHUNK_MAX_BEATS.

Optional Feature:
AXI4_ENC_4K_SPLIT_EN
- Defined: a command whose bytes cross a 4 KB boundary, i.e. in_addr[11:0] + beats*(DATA_WIDTH/8) > 4096, is issued as two bursts in SEND.
  - Burst 1: b1=(4096-in_addr[11:0])/(DATA_WIDTH/8) beats at in_addr.
  - Burst 2: the remaining beats at (in_addr & ~12'hFFF)+4096, using the next ID.
  - wlast asserts at the end of each burst. Burst 2's AW issues only after burst 1's AW handshake.
  - in_ready additionally requires outstanding<=MAX_OUTSTANDING-2.
- Undefined: always a single burst. Crossing is the requester's responsibility.

Test Plan:
- Reset, then command addr=0x1000, len=4, beats D0..D3 with awready=wready=1 -> awvalid at cycle+1, awlen=3, awsize=5, awburst=1. Four W beats D0..D3, wlast on D3. outstanding=1. B OKAY -> outstanding=0.
- len=1 at 0x20 with awready held low 5 cycles, wready=1 -> W beat/wlast completes first. AW stays stable until ready. in_ready returns to 1 only after the AW handshake.
- Issue 4 bursts with no B responses (MAX_OUTSTANDING=4) -> in_ready=0 while outstanding=4. Return one B -> in_ready=1. AW handshake and B in the same cycle -> outstanding unchanged.
- B with bid=2, bresp=2'b10 -> err_valid pulses one cycle, err_id=2. outstanding decrements.
- Assert rst mid-burst after 2 of 4 beats -> all valids low immediately. outstanding=0. A next command starts cleanly with awid=0.
- With AXI4_ENC_4K_SPLIT_EN: addr=0x0FC0, len=4 -> burst 1 addr 0x0FC0 awlen=1, wlast on beat 1. Burst 2 addr 0x1000 awlen=1, awid+1. outstanding=2.

Source files
------------

// File: rtl/axi4_if_encoding_if.sv
// axi4_if_encoding_if: AXI4 write-direction AW/W/B channel bundle.
interface axi4_if_encoding_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256
);
  logic [ID_WIDTH-1:0]     m_axi_awid;
  logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
  logic [7:0]              m_axi_awlen;
  logic [2:0]              m_axi_awsize;
  logic [1:0]              m_axi_awburst;
  logic                    m_axi_awvalid;
  logic                    m_axi_awready;
  logic [DATA_WIDTH-1:0]   m_axi_wdata;
  logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
  logic                    m_axi_wlast;
  logic                    m_axi_wvalid;
  logic                    m_axi_wready;
  logic [ID_WIDTH-1:0]     m_axi_bid;
  logic [1:0]              m_axi_bresp;
  logic                    m_axi_bvalid;
  logic                    m_axi_bready;
  modport master (
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output m_axi_bready
  );
  modport slave (
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready
  );
endinterface

// File: rtl/axi4_if_encoding.sv
// axi4_if_encoding: command-to-AXI4 INCR write burst encoder with B tracking.
// Define AXI4_ENC_4K_SPLIT_EN to split commands that cross a 4 KB boundary.
module axi4_if_encoding #(
  parameter int ID_WIDTH        = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 256,
  parameter int CHUNK_MAX_BEATS = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [ADDR_WIDTH-1:0]                 in_addr,
  input  logic [7:0]                            in_length,
  input  logic [CHUNK_MAX_BEATS*DATA_WIDTH-1:0] in_wdata,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  axi4_if_encoding_if.master                    m,
  output logic                                  err_valid,
  output logic [ID_WIDTH-1:0]                   err_id,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding
);
  localparam int BB = DATA_WIDTH / 8;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr2_q, addr2_d;
  logic [7:0] len_q, len_d, len2_q, len2_d, cnt_q, cnt_d, beats_q, beats_d, b1_q, b1_d;
  logic [ID_WIDTH-1:0] id_q, id_d, err_id_q, err_id_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, split_q, split_d, aw2_q, aw2_d;
  logic err_valid_q, err_valid_d;
  logic [OW-1:0] out_q, out_d;
  logic [CHUNK_MAX_BEATS*DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [7:0] beats, b1;
  logic split, aw_hs, w_hs, b_hs, last_beat, aw_fin, w_fin;
  assign aw_hs = awvalid_q & m.m_axi_awready;
  assign w_hs = wvalid_q & m.m_axi_wready;
  assign b_hs = m.m_axi_bvalid & m.m_axi_bready;
  assign last_beat = cnt_q == beats_q - 8'd1;
  always_comb begin
    beats = in_length == 8'd0 ? 8'd1 : (32'(in_length) > CHUNK_MAX_BEATS ? 8'(CHUNK_MAX_BEATS) : in_length);
    b1 = 8'((32'd4096 - 32'(in_addr[11:0])) / BB);
`ifdef AXI4_ENC_4K_SPLIT_EN
    split = 32'(in_addr[11:0]) + 32'(beats) * BB > 32'd4096;
    in_ready = state_q == IDLE && 32'(out_q) + 2 <= MAX_OUTSTANDING;
`else
    split = 1'b0;
    in_ready = state_q == IDLE && 32'(out_q) < MAX_OUTSTANDING;
`endif
    aw_fin = !aw2_q && (!awvalid_q || aw_hs);
    w_fin = !wvalid_q || (w_hs && last_beat);
    state_d = state_q;
    addr_d = addr_q;
    addr2_d = addr2_q;
    len_d = len_q;
    len2_d = len2_q;
    cnt_d = cnt_q;
    beats_d = beats_q;
    b1_d = b1_q;
    split_d = split_q;
    aw2_d = aw2_q;
    awvalid_d = awvalid_q;
    wvalid_d = wvalid_q;
    wdata_d = wdata_q;
    if (state_q == IDLE && in_valid && in_ready) begin
      state_d = SEND;
      addr_d = in_addr;
      addr2_d = {in_addr[ADDR_WIDTH-1:12], 12'h000} + ADDR_WIDTH'(4096);
      len_d = split ? b1 - 8'd1 : beats - 8'd1;
      len2_d = beats - b1 - 8'd1;
      cnt_d = 8'd0;
      beats_d = beats;
      b1_d = b1;
      split_d = split;
      aw2_d = split;
      awvalid_d = 1'b1;
      wvalid_d = 1'b1;
      wdata_d = in_wdata;
    end else if (state_q == SEND) begin
      // second burst's AW takes over the channel right after the first handshakes
      if (aw_hs) begin
        awvalid_d = aw2_q;
        aw2_d = 1'b0;
        addr_d = aw2_q ? addr2_q : addr_q;
        len_d = aw2_q ? len2_q : len_q;
      end
      if (w_hs) begin
        cnt_d = last_beat ? cnt_q : cnt_q + 8'd1;
        wvalid_d = !last_beat;
      end
      if (aw_fin && w_fin) state_d = IDLE;
    end
    id_d = id_q + ID_WIDTH'(aw_hs);
    out_d = out_q + OW'(aw_hs) - OW'(b_hs && out_q != '0);
    err_valid_d = b_hs && m.m_axi_bresp != 2'b00;
    err_id_d = err_valid_d ? m.m_axi_bid : err_id_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      addr2_q <= '0;
      len_q <= '0;
      len2_q <= '0;
      cnt_q <= '0;
      beats_q <= 8'd1;
      b1_q <= '0;
      split_q <= 1'b0;
      aw2_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      wdata_q <= '0;
      id_q <= '0;
      out_q <= '0;
      err_valid_q <= 1'b0;
      err_id_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      addr2_q <= addr2_d;
      len_q <= len_d;
      len2_q <= len2_d;
      cnt_q <= cnt_d;
      beats_q <= beats_d;
      b1_q <= b1_d;
      split_q <= split_d;
      aw2_q <= aw2_d;
      awvalid_q <= awvalid_d;
      wvalid_q <= wvalid_d;
      wdata_q <= wdata_d;
      id_q <= id_d;
      out_q <= out_d;
      err_valid_q <= err_valid_d;
      err_id_q <= err_id_d;
    end
  end
  assign m.m_axi_awid = id_q;
  assign m.m_axi_awaddr = addr_q;
  assign m.m_axi_awlen = len_q;
  assign m.m_axi_awsize = 3'($clog2(BB));
  assign m.m_axi_awburst = 2'b01;
  assign m.m_axi_awvalid = awvalid_q;
  assign m.m_axi_wdata = wdata_q[cnt_q*DATA_WIDTH +: DATA_WIDTH];
  assign m.m_axi_wstrb = '1;
  assign m.m_axi_wlast = last_beat || (split_q && cnt_q == b1_q - 8'd1);
  assign m.m_axi_wvalid = wvalid_q;
  assign m.m_axi_bready = ~rst;
  assign err_valid = err_valid_q;
  assign err_id = err_id_q;
  assign outstanding = out_q;
endmodule

// File: tb/tb_axi4_if_encoding.sv
// tb_axi4_if_encoding: directed vector table plus hand sequences for stalls, back-pressure, errors and reset.
module tb_axi4_if_encoding;
  localparam int DW = 256;
  localparam int CMB = 4;
`ifdef AXI4_ENC_4K_SPLIT_EN
  localparam int NFILL = 3;
`else
  localparam int NFILL = 4;
`endif
  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    int          beats;
    int          aw_delay;
  } vec_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [31:0] in_addr = 0;
  logic [7:0] in_length = 0;
  logic [CMB*DW-1:0] in_wdata = '0;
  logic in_valid = 0, in_ready, err_valid;
  logic [3:0] err_id;
  logic [2:0] outstanding;
  logic [3:0] nid = 0;
  int total = 0, bad = 0;
  axi4_if_encoding_if ax ();
  axi4_if_encoding dut (
    .clk(clk), .rst(rst), .in_addr(in_addr), .in_length(in_length), .in_wdata(in_wdata),
    .in_valid(in_valid), .in_ready(in_ready), .m(ax.master), .err_valid(err_valid),
    .err_id(err_id), .outstanding(outstanding)
  );
  function automatic logic [DW-1:0] pat(input int v, input int k);
    return {8{16'(v), 16'(k + 160)}};
  endfunction
  task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask
  task automatic accept(input logic [31:0] a, input logic [7:0] len, input int v);
    int w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_idle", in_ready, 1);
    in_addr = a;
    in_length = len;
    for (int k = 0; k < CMB; k++) in_wdata[k*DW +: DW] = pat(v, k);
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    chk("awvalid_latency", ax.m_axi_awvalid, 1);
    chk("wvalid_latency", ax.m_axi_wvalid, 1);
  endtask
  task automatic do_burst(input logic [31:0] a, input int beats, input int v, input int aw_delay);
    int k = 0, cyc = 0;
    bit awd = 0;
    ax.m_axi_wready = 1;
    while ((!awd || k < beats) && cyc < 40) begin
      ax.m_axi_awready = cyc >= aw_delay;
      chk("in_ready_send", in_ready, 0);
      chk("awvalid", ax.m_axi_awvalid, !awd);
      if (ax.m_axi_awvalid) begin
        chk("awaddr", ax.m_axi_awaddr, a);
        chk("awlen", ax.m_axi_awlen, 8'(beats - 1));
        chk("awid", ax.m_axi_awid, nid);
        chk("awsize", ax.m_axi_awsize, 5);
        chk("awburst", ax.m_axi_awburst, 1);
        if (ax.m_axi_awready) begin
          awd = 1;
          nid++;
        end
      end
      if (k < beats) begin
        chk("wvalid", ax.m_axi_wvalid, 1);
        chk("wdata", ax.m_axi_wdata, pat(v, k));
        chk("wlast", ax.m_axi_wlast, k == beats - 1);
        chk("wstrb", ax.m_axi_wstrb, 32'hFFFF_FFFF);
        k++;
      end else chk("wvalid_done", ax.m_axi_wvalid, 0);
      @(negedge clk);
      cyc++;
    end
    ax.m_axi_awready = 0;
    ax.m_axi_wready = 0;
    if (cyc >= 40) chk("burst_timeout", 1, 0);
    chk("awvalid_end", ax.m_axi_awvalid, 0);
    chk("wvalid_end", ax.m_axi_wvalid, 0);
  endtask
  task automatic b_resp(input logic [3:0] id, input logic [1:0] resp, input int exp_out);
    ax.m_axi_bvalid = 1;
    ax.m_axi_bid = id;
    ax.m_axi_bresp = resp;
    @(negedge clk);
    ax.m_axi_bvalid = 0;
    ax.m_axi_bresp = 0;
    chk("err_valid", err_valid, resp != 0);
    if (resp != 0) chk("err_id", err_id, id);
    chk("outstanding_b", outstanding, exp_out);
  endtask
  initial begin
    vec_t vecs[5];
    vecs[0] = '{32'h1000, 8'd4, 4, 0};
    vecs[1] = '{32'h0020, 8'd1, 1, 5};
    vecs[2] = '{32'h0040, 8'd0, 1, 0};
    vecs[3] = '{32'h0080, 8'd9, 4, 2};
    vecs[4] = '{32'h0100, 8'd2, 2, 1};
    ax.m_axi_awready = 0;
    ax.m_axi_wready = 0;
    ax.m_axi_bvalid = 0;
    ax.m_axi_bid = 0;
    ax.m_axi_bresp = 0;
    @(negedge clk);
    chk("rst_awvalid", ax.m_axi_awvalid, 0);
    chk("rst_wvalid", ax.m_axi_wvalid, 0);
    chk("rst_bready", ax.m_axi_bready, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err_valid", err_valid, 0);
    chk("rst_err_id", err_id, 0);
    rst = 0;
    @(negedge clk);
    chk("bready_run", ax.m_axi_bready, 1);
    for (int i = 0; i < 5; i++) begin
      accept(vecs[i].addr, vecs[i].len, i);
      do_burst(vecs[i].addr, vecs[i].beats, i, vecs[i].aw_delay);
      chk("outstanding_one", outstanding, 1);
      chk("in_ready_after", in_ready, 1);
      b_resp(nid - 4'd1, 2'b00, 0);
    end
    for (int i = 0; i < NFILL; i++) begin
      accept(32'h200 + 32'(i) * 32, 8'd1, 10 + i);
      do_burst(32'h200 + 32'(i) * 32, 1, 10 + i, 0);
      chk("outstanding_fill", outstanding, i + 1);
    end
    repeat (2) begin
      chk("in_ready_full", in_ready, 0);
      @(negedge clk);
    end
    b_resp(4'd5, 2'b00, NFILL - 1);
    chk("in_ready_freed", in_ready, 1);
    accept(32'h300, 8'd1, 20);
    chk("same_awid", ax.m_axi_awid, nid);
    chk("same_wlast", ax.m_axi_wlast, 1);
    ax.m_axi_bvalid = 1;
    ax.m_axi_bid = 4'd6;
    ax.m_axi_awready = 1;
    ax.m_axi_wready = 1;
    @(negedge clk);
    nid++;
    ax.m_axi_bvalid = 0;
    ax.m_axi_awready = 0;
    ax.m_axi_wready = 0;
    chk("same_cycle_outstanding", outstanding, NFILL - 1);
    chk("same_awvalid", ax.m_axi_awvalid, 0);
    chk("same_wvalid", ax.m_axi_wvalid, 0);
    chk("same_in_ready", in_ready, 1);
    b_resp(4'd2, 2'b10, NFILL - 2);
    @(negedge clk);
    chk("err_pulse_end", err_valid, 0);
    chk("err_id_hold", err_id, 2);
    for (int i = NFILL - 3; i >= 0; i--) b_resp(4'd1, 2'b00, i);
    chk("err_id_kept", err_id, 2);
    b_resp(4'd0, 2'b00, 0);
    accept(32'h400, 8'd4, 30);
    ax.m_axi_awready = 1;
    ax.m_axi_wready = 1;
    @(negedge clk);
    ax.m_axi_awready = 0;
    @(negedge clk);
    ax.m_axi_wready = 0;
    chk("pre_rst_outstanding", outstanding, 1);
    chk("pre_rst_wvalid", ax.m_axi_wvalid, 1);
    rst = 1;
    #1;
    chk("midrst_awvalid", ax.m_axi_awvalid, 0);
    chk("midrst_wvalid", ax.m_axi_wvalid, 0);
    chk("midrst_outstanding", outstanding, 0);
    @(negedge clk);
    rst = 0;
    nid = 0;
    @(negedge clk);
    chk("post_rst_wvalid", ax.m_axi_wvalid, 0);
    accept(32'h500, 8'd2, 40);
    do_burst(32'h500, 2, 40, 0);
    chk("post_rst_outstanding", outstanding, 1);
    b_resp(4'd0, 2'b00, 0);
`ifdef AXI4_ENC_4K_SPLIT_EN
    accept(32'h0FC0, 8'd4, 50);
    ax.m_axi_awready = 1;
    ax.m_axi_wready = 1;
    chk("s1_awaddr", ax.m_axi_awaddr, 32'h0FC0);
    chk("s1_awlen", ax.m_axi_awlen, 1);
    chk("s1_awid", ax.m_axi_awid, nid);
    chk("s_wdata0", ax.m_axi_wdata, pat(50, 0));
    chk("s_wlast0", ax.m_axi_wlast, 0);
    @(negedge clk);
    chk("s2_awvalid", ax.m_axi_awvalid, 1);
    chk("s2_awaddr", ax.m_axi_awaddr, 32'h1000);
    chk("s2_awlen", ax.m_axi_awlen, 1);
    chk("s2_awid", ax.m_axi_awid, nid + 4'd1);
    chk("s_wdata1", ax.m_axi_wdata, pat(50, 1));
    chk("s_wlast1", ax.m_axi_wlast, 1);
    @(negedge clk);
    chk("s_awvalid_off", ax.m_axi_awvalid, 0);
    chk("s_wdata2", ax.m_axi_wdata, pat(50, 2));
    chk("s_wlast2", ax.m_axi_wlast, 0);
    @(negedge clk);
    chk("s_wdata3", ax.m_axi_wdata, pat(50, 3));
    chk("s_wlast3", ax.m_axi_wlast, 1);
    @(negedge clk);
    ax.m_axi_awready = 0;
    ax.m_axi_wready = 0;
    nid = nid + 4'd2;
    chk("s_wvalid_end", ax.m_axi_wvalid, 0);
    chk("s_outstanding", outstanding, 2);
    chk("s_in_ready", in_ready, 1);
    b_resp(nid - 4'd2, 2'b00, 1);
    b_resp(nid - 4'd1, 2'b00, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
